// File: rtl/vga_pkg.sv
// Shared constants and mode encodings for the VGA pixel fetch stage.
package vga_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned BAR_W     = 80;
    localparam int unsigned CHECK_BIT = 5;

    localparam int unsigned XW    = $clog2(H_ACTIVE);
    localparam int unsigned YW    = $clog2(V_ACTIVE);
    localparam int unsigned SUB_W = $clog2(BAR_W);

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    localparam logic [11:0] BAR_COLOURS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // {pixel, h_sync, v_sync, mode[1:0], pattern[11:0]}
    localparam int unsigned BUNDLE_W = 17;

endpackage

// File: rtl/vga_delay.sv
// N-stage registered delay line with a per-bit reset value.
module vga_delay #(
    parameter int unsigned W       = 1,
    parameter int unsigned N       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer/test-pattern pixel source with sync realignment for 640x480 VGA.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel,
    input  logic [18:0] p_count,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [1:0]  mode,
    output logic [18:0] fb_addr,
    output logic        fb_rd,
    input  logic [11:0] fb_data,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic [1:0]  mode_act,
    output logic [7:0]  frame_cnt
);

    localparam logic [BUNDLE_W-1:0] BUNDLE_RST = {1'b0, 1'b1, 1'b1, 2'b00, 12'h000};

    logic             pix_q, hs_q, vs_q;
    mode_e            mode_q, mode_act_q;
    logic [11:0]      pat_q, pat_d;
    logic             fb_rd_q;
    logic [18:0]      fb_addr_q;
    logic [7:0]       frame_cnt_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [2:0]       bar_q;
    logic [SUB_W-1:0] sub_q;

    logic             fbe, pix_fall;

    assign fbe      = vs_q & ~v_sync_in;
    assign pix_fall = pix_q & ~pixel;

    // Pattern from the pre-increment column/row, i.e. the pixel being sampled now.
    always_comb begin
        pat_d = 12'h000;
        case (mode_act_q)
            MODE_BARS:  pat_d = BAR_COLOURS[bar_q];
            MODE_CHECK: pat_d = (x_q[CHECK_BIT] ^ y_q[CHECK_BIT]) ? 12'hFFF : 12'h000;
            default:    pat_d = 12'h000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            mode_q      <= MODE_FB;
            mode_act_q  <= MODE_FB;
            pat_q       <= 12'h000;
            fb_rd_q     <= 1'b0;
            fb_addr_q   <= '0;
            frame_cnt_q <= 8'd0;
            x_q         <= '0;
            y_q         <= '0;
            bar_q       <= 3'd0;
            sub_q       <= '0;
        end else begin
            pix_q   <= pixel;
            hs_q    <= h_sync_in;
            vs_q    <= v_sync_in;
            mode_q  <= mode_act_q;
            pat_q   <= pat_d;
            fb_rd_q <= pixel && (mode_act_q == MODE_FB);
            if (pixel) fb_addr_q <= p_count;

            if (fbe) begin
                mode_act_q  <= mode_e'(mode);
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end

            if (pixel) begin
                x_q <= x_q + 1'b1;
                if (sub_q == SUB_W'(BAR_W - 1)) begin
                    sub_q <= '0;
                    bar_q <= bar_q + 3'd1;
                end else begin
                    sub_q <= sub_q + 1'b1;
                end
            end else begin
                x_q   <= '0;
                sub_q <= '0;
                bar_q <= 3'd0;
            end

            if (fbe)           y_q <= '0;
            else if (pix_fall) y_q <= y_q + 1'b1;
        end
    end

    logic [BUNDLE_W-1:0] bundle_dl;
    logic                pix_dl, hs_dl, vs_dl;
    logic [1:0]          mode_dl;
    logic [11:0]         pat_dl;

    // Aligns the stage-0 view of the pixel with framebuffer read data.
    vga_delay #(
        .W       (BUNDLE_W),
        .N       (RD_LAT),
        .RST_VAL (BUNDLE_RST)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({pix_q, hs_q, vs_q, mode_q, pat_q}),
        .dout  (bundle_dl)
    );

    assign {pix_dl, hs_dl, vs_dl, mode_dl, pat_dl} = bundle_dl;

    logic [11:0] rgb_d, rgb_q;
    logic        h_sync_q, v_sync_q;

    always_comb begin
        rgb_d = 12'h000;
        if (pix_dl) begin
            case (mode_e'(mode_dl))
                MODE_FB:    rgb_d = fb_data;
                MODE_BARS:  rgb_d = pat_dl;
                MODE_CHECK: rgb_d = pat_dl;
                default:    rgb_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_sync_q <= 1'b1;
            v_sync_q <= 1'b1;
            rgb_q    <= 12'h000;
        end else begin
            h_sync_q <= hs_dl;
            v_sync_q <= vs_dl;
            rgb_q    <= rgb_d;
        end
    end

    assign h_sync    = h_sync_q;
    assign v_sync    = v_sync_q;
    assign {r, g, b} = rgb_q;
    assign fb_rd     = fb_rd_q;
    assign fb_addr   = fb_addr_q;
    assign mode_act  = mode_act_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch at RD_LAT=1 and RD_LAT=4 sharing one stimulus.
module tb_vga_pixel_fetch;

    localparam int L1 = 3;
    localparam int L4 = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pixel;
    logic [18:0] p_count;
    logic        h_in, v_in;
    logic [1:0]  mode;
    logic        fb_force;

    logic [18:0] fb_addr1, fb_addr4;
    logic        fb_rd1, fb_rd4;
    logic [11:0] fb_data1, fb_data4;
    logic        h1, v1, h4, v4;
    logic [3:0]  r1, g1, b1, r4, g4, b4;
    logic [1:0]  mact1, mact4;
    logic [7:0]  fc1, fc4;

    always #5 clk = ~clk;

    vga_pixel_fetch #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .p_count(p_count),
        .h_sync_in(h_in), .v_sync_in(v_in), .mode(mode),
        .fb_addr(fb_addr1), .fb_rd(fb_rd1), .fb_data(fb_data1),
        .h_sync(h1), .v_sync(v1), .r(r1), .g(g1), .b(b1),
        .mode_act(mact1), .frame_cnt(fc1)
    );

    vga_pixel_fetch #(.RD_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .p_count(p_count),
        .h_sync_in(h_in), .v_sync_in(v_in), .mode(mode),
        .fb_addr(fb_addr4), .fb_rd(fb_rd4), .fb_data(fb_data4),
        .h_sync(h4), .v_sync(v4), .r(r4), .g(g4), .b(b4),
        .mode_act(mact4), .frame_cnt(fc4)
    );

    // Framebuffer models: data = addr[11:0], RD_LAT edges after the address is presented.
    logic [11:0] fb1_s;
    logic [11:0] fb4_s [4];
    always @(posedge clk) begin
        fb1_s    <= fb_force ? 12'hFFF : fb_addr1[11:0];
        fb4_s[0] <= fb_force ? 12'hFFF : fb_addr4[11:0];
        for (int i = 1; i < 4; i++) fb4_s[i] <= fb4_s[i-1];
    end
    assign fb_data1 = fb1_s;
    assign fb_data4 = fb4_s[3];

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t        q1[$];
    exp_t        q4[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [1:0]  m_mode;
    logic [7:0]  m_fc;
    int          col, row;
    logic        prev_p, vs_prev;
    logic        exp_fbrd;
    logic [18:0] exp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bar_ref(input int k);
        case (k)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode   = 2'd0;
        m_fc     = 8'd0;
        col      = 0;
        row      = 0;
        prev_p   = 1'b0;
        vs_prev  = 1'b1;
        exp_fbrd = 1'b0;
        exp_addr = '0;
        q1.delete();
        q4.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb1"}, {r1, g1, b1}, 0);
        check({tag, "_rgb4"}, {r4, g4, b4}, 0);
        check({tag, "_hs1"}, h1, 1);
        check({tag, "_vs1"}, v1, 1);
        check({tag, "_hs4"}, h4, 1);
        check({tag, "_vs4"}, v4, 1);
        check({tag, "_fbrd1"}, fb_rd1, 0);
        check({tag, "_fbrd4"}, fb_rd4, 0);
        check({tag, "_fbaddr1"}, fb_addr1, 0);
        check({tag, "_fbaddr4"}, fb_addr4, 0);
        check({tag, "_mact1"}, mact1, 0);
        check({tag, "_mact4"}, mact4, 0);
        check({tag, "_fc1"}, fc1, 0);
        check({tag, "_fc4"}, fc4, 0);
    endtask

    // One pixel clock: check what the DUTs produce now, then drive and predict the next input.
    task automatic cyc(input logic p, input int pc, input logic hs, input logic vs);
        exp_t e;
        logic [11:0] er;
        @(negedge clk);
        if (q1.size() == L1) begin
            e = q1.pop_front();
            check("rgb1", {r1, g1, b1}, e.rgb);
            check("hs1", h1, e.hs);
            check("vs1", v1, e.vs);
        end
        if (q4.size() == L4) begin
            e = q4.pop_front();
            check("rgb4", {r4, g4, b4}, e.rgb);
            check("hs4", h4, e.hs);
            check("vs4", v4, e.vs);
        end
        check("fbrd1", fb_rd1, exp_fbrd);
        check("fbaddr1", fb_addr1, exp_addr);
        check("fbrd4", fb_rd4, exp_fbrd);
        check("fbaddr4", fb_addr4, exp_addr);
        check("mact1", mact1, m_mode);
        check("mact4", mact4, m_mode);
        check("fc1", fc1, m_fc);
        check("fc4", fc4, m_fc);

        pixel   = p;
        p_count = 19'(pc);
        h_in    = hs;
        v_in    = vs;

        er = 12'h000;
        if (p) begin
            case (m_mode)
                2'd0:    er = fb_force ? 12'hFFF : 12'(pc);
                2'd1:    er = bar_ref(col / 80);
                2'd2:    er = (((col >> 5) ^ (row >> 5)) & 1) != 0 ? 12'hFFF : 12'h000;
                default: er = 12'h000;
            endcase
        end
        e.hs  = hs;
        e.vs  = vs;
        e.rgb = er;
        q1.push_back(e);
        q4.push_back(e);

        exp_fbrd = p && (m_mode == 2'd0);
        if (p) exp_addr = 19'(pc);

        if (vs_prev && !vs) begin
            m_mode = mode;
            m_fc   = m_fc + 8'd1;
            row    = 0;
        end else if (prev_p && !p) begin
            row = row + 1;
        end
        col     = p ? col + 1 : 0;
        prev_p  = p;
        vs_prev = vs;
    endtask

    task automatic run_line(input int npix, input int base);
        for (int i = 0; i < npix; i++) cyc(1'b1, base + i, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of stimulus, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        pixel    = 1'b0;
        p_count  = '0;
        h_in     = 1'b1;
        v_in     = 1'b1;
        mode     = 2'd0;
        fb_force = 1'b0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Framebuffer mode straight after reset.
        run_line(16, 0);
        run_line(16, 640);

        // Colour bars over a full line.
        mode = 2'd1;
        vsync_pulse();
        run_line(640, 0);

        // Request checkerboard mid-frame: bars must persist until the frame boundary.
        mode = 2'd2;
        run_line(640, 640);
        vsync_pulse();
        for (int rr = 0; rr < 34; rr++) run_line(64, rr * 640);

        // Blanking must stay black even when the framebuffer returns white.
        mode = 2'd0;
        vsync_pulse();
        fb_force = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        fb_force = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 0, 1'b1, 1'b1);
        run_line(8, 1000);

        mode = 2'd3;
        vsync_pulse();
        run_line(8, 0);

        // Frame counter wrap 255 -> 0.
        mode = 2'd0;
        while (m_fc != 8'd255) vsync_pulse();
        vsync_pulse();
        check("fc_wrap1", fc1, 0);
        check("fc_wrap4", fc4, 0);

        // Mid-line asynchronous reset with a non-framebuffer mode in effect.
        mode = 2'd2;
        vsync_pulse();
        vsync_pulse();
        for (int i = 0; i < 20; i++) cyc(1'b1, 100 + i, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        pixel   = 1'b0;
        p_count = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_line(16, 100);
        run_line(8, 200);

        for (int i = 0; i < L4 + 2; i++) cyc(1'b0, 0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Downstream stage of the 640x480 VGA timing generator. It consumes the generator's active-pixel flag, linear pixel index and sync outputs, and reads 12-bit RGB pixels from a synchronous-read framebuffer. Alternatively it synthesises a test pattern. It delays the syncs to match the pixel-data latency and drives the DAC/connector pins with blanking-clean 4:4:4 RGB.

## Interface
- RD_LAT, default 1: framebuffer read latency in cycles, from FB_RD sampled to FB_DATA valid; legal range 1..4.
- CLK  in  1  pixel clock (25.175 MHz), same clock as the timing generator.
- RST  in  1  reset; asynchronous, active-low.
- PIXEL  in  1  active-area flag from the timing generator.
- P_COUNT  in  19  linear pixel index, 0..307199; valid while PIXEL=1.
- H_SYNC_IN  in  1  horizontal sync from the generator, active-low.
- V_SYNC_IN  in  1  vertical sync from the generator, active-low.
- MODE  in  2  requested source: 0 framebuffer, 1 colour bars, 2 checkerboard, 3 black.
- FB_ADDR  out  19  framebuffer read address.
- FB_RD  out  1  framebuffer read strobe.
- FB_DATA  in  12  read data {R[3:0],G[3:0],B[3:0]}.
- H_SYNC, V_SYNC  out  1  delayed syncs, active-low.
- R, G, B  out  4 each  pixel colour.
- MODE_ACT  out  2  mode in effect for the current frame.
- FRAME_CNT  out  8  frame counter.

## Operation
- Reset values: H_SYNC=1, V_SYNC=1, R=G=B=0, FB_RD=0, FB_ADDR=0, MODE_ACT=0, FRAME_CNT=0. All internal counters and delay-line stages clear; delayed syncs reset to 1.
- Frame boundary event (FBE): falling edge of V_SYNC_IN, detected against a registered copy.
- At FBE:
  - MODE_ACT <= MODE.
  - FRAME_CNT <= FRAME_CNT+1, wrapping 255->0.
  - Row counter clears.
- MODE changes between FBEs are ignored.
- Stage 0 (registered):
  - FB_RD <= PIXEL && MODE_ACT==0.
  - FB_ADDR <= P_COUNT when PIXEL=1, otherwise hold.
- Column counter x (10 bit): clears while PIXEL=0, increments while PIXEL=1.
- Row counter y (9 bit): increments on each falling edge of PIXEL.
- Colour bars (mode 1):
  - 8 bars of 80 pixels each.
  - Tracked with a bar index (3 bit) and a sub-counter 0..79 that wraps and bumps the bar index. Both clear with x.
  - Bar order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
- Checkerboard (mode 2): FFF when x[5]^y[5]=1, else 000.
- Pattern colour is computed in stage 0 from the pre-increment x/y. It is then delayed RD_LAT cycles so it aligns with FB_DATA.
- Output stage (registered):
  - RGB = 0 when the delayed PIXEL is 0.
  - Otherwise RGB = FB_DATA (mode 0), the delayed pattern (modes 1/2), or 0 (mode 3).
  - The mode used is MODE_ACT sampled alongside the pixel, so an FBE never changes mode mid-line.
- Reset mid-frame: outputs return to reset values asynchronously. After RST deasserts, MODE_ACT stays 0 until the next FBE. Syncs resume after the pipeline latency.

## Timing
- Total latency L = RD_LAT+2 cycles, applied identically to PIXEL, H_SYNC_IN, V_SYNC_IN and pixel colour. Input at edge n appears on the outputs after edge n+L.
- FB_RD/FB_ADDR lag PIXEL/P_COUNT by exactly 1 cycle.
- No backpressure: the framebuffer must return data on every cycle exactly RD_LAT after FB_RD.
- FBE at edge n updates MODE_ACT and FRAME_CNT visibly after edge n+1.
- The first active pixel of the next frame arrives 35 lines later, so the mode switch is always clean.
- Bar boundaries: bar k covers x = 80k..80k+79.

## Structure
- vga_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480, BAR_W=80, CHECK_BIT=5.
  - Mode encodings MODE_FB/MODE_BARS/MODE_CHECK/MODE_BLACK.
  - The 8-entry bar colour constant array.
- Sub-module vga_delay #(W, N): N-stage registered delay line with asynchronous active-low reset. Instantiated once for the bundle {PIXEL, H_SYNC_IN, V_SYNC_IN, mode, pattern}. Sync bits reset to 1, all other bits to 0.
- State registers use the existing REG block.

## Test plan
- Reset release, mode 0, RD_LAT=1, framebuffer model returns addr[11:0]:
  - Pixel 0 of a line: RGB=000 exactly 3 cycles after PIXEL rises.
  - FB_ADDR=5 one cycle after P_COUNT=5.
  - H_SYNC falls exactly 3 cycles after H_SYNC_IN.
- Mode 1 full line:
  - x=0..79 -> RGB FFF; x=80 -> FF0; x=639 -> 000.
  - FB_RD stays 0 throughout.
- Mode 2:
  - Row 0: x=31 -> FFF? No: x=31 -> 000, x=32 -> FFF.
  - Row 32: x=0 -> FFF.
- MODE changed 1->2 mid-frame:
  - MODE_ACT stays 1 until V_SYNC_IN falls, then becomes 2.
  - The next frame is checkerboard with no mixed line.
- FRAME_CNT=255 at FBE -> 0. Blanking with FB_DATA=FFF -> RGB=000.
- RST asserted mid-line with RD_LAT=4:
  - All outputs reach reset values immediately.
  - After release, the first RGB!=0 appears 6 cycles after PIXEL rises.
